// File: rtl/spi_slave_single_cs.sv
// rtl/spi_slave_single_cs.sv - SPI mode-0 slave, one chip select; optional o_Frame_Err via SPI_SLAVE_FRAME_ERR_EN
module spi_slave_single_cs #(
    parameter int                DATA_W       = 8,
    parameter int                COUNT_W      = 8,
    parameter logic [DATA_W-1:0] TX_IDLE_WORD = '1
) (
    input  logic               i_Clk,
    input  logic               i_Rst_L,
    output logic               o_RX_DV,
    output logic [DATA_W-1:0]  o_RX_Byte,
    output logic [COUNT_W-1:0] o_RX_Count,
    input  logic               i_TX_DV,
    input  logic [DATA_W-1:0]  i_TX_Byte,
    output logic               o_TX_Ready,
    output logic               o_Busy,
`ifdef SPI_SLAVE_FRAME_ERR_EN
    output logic               o_Frame_Err,
`endif
    input  logic               i_SPI_Clk,
    input  logic               i_SPI_MOSI,
    output logic               o_SPI_MISO,
    input  logic               i_SPI_CS_n
);

    localparam int BIT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {S_WAIT, S_IDLE, S_SHIFT} state_t;

    state_t              state_q, state_d;
    logic                sclk_s1, sclk_s2, sclk_d;
    logic                mosi_s1, mosi_s2;
    logic                cs_s1, cs_s2;
    logic [BIT_W-1:0]    bit_cnt;
    logic [DATA_W-1:0]   rx_shift;
    logic                word_done;
    logic                got_word;
    logic [DATA_W-1:0]   tx_shift;
    logic [DATA_W-1:0]   tx_hold;
    logic                tx_pending;

    logic in_shift, frame_start, frame_end;
    logic sclk_rise, sclk_fall, last_bit;
    logic rx_evt, load_evt, shift_evt;

    assign sclk_rise   = sclk_s2 & ~sclk_d;
    assign sclk_fall   = ~sclk_s2 & sclk_d;
    assign in_shift    = (state_q == S_SHIFT);
    assign frame_start = (state_q == S_IDLE) && !cs_s2;
    assign frame_end   = in_shift && cs_s2;
    assign last_bit    = (bit_cnt == BIT_W'(DATA_W - 1));
    assign rx_evt      = in_shift && !cs_s2 && sclk_rise;
    // Word boundary falls (bit_cnt==0) reload the shifter; every other fall advances it.
    assign load_evt    = frame_start || (in_shift && !cs_s2 && sclk_fall && (bit_cnt == '0));
    assign shift_evt   = in_shift && !cs_s2 && sclk_fall && (bit_cnt != '0);

    assign o_TX_Ready  = ~tx_pending;
    assign o_Busy      = in_shift;

    // Pin synchronizers; CS_n resets low so a frame already in flight at reset is waited out.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            sclk_s1 <= 1'b0; sclk_s2 <= 1'b0; sclk_d <= 1'b0;
            mosi_s1 <= 1'b0; mosi_s2 <= 1'b0;
            cs_s1   <= 1'b0; cs_s2   <= 1'b0;
        end else begin
            sclk_s1 <= i_SPI_Clk;  sclk_s2 <= sclk_s1; sclk_d <= sclk_s2;
            mosi_s1 <= i_SPI_MOSI; mosi_s2 <= mosi_s1;
            cs_s1   <= i_SPI_CS_n; cs_s2   <= cs_s1;
        end
    end

    // Frame state register.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) state_q <= S_WAIT;
        else          state_q <= state_d;
    end

    // Frame next-state: wait for CS_n high after reset, then track CS_n level.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT:  if (cs_s2)  state_d = S_IDLE;
            S_IDLE:  if (!cs_s2) state_d = S_SHIFT;
            S_SHIFT: if (cs_s2)  state_d = S_IDLE;
            default:             state_d = S_WAIT;
        endcase
    end

    // Receive path: bit assembly, word strobe one cycle after the last bit, per-frame word count.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            bit_cnt    <= '0;
            rx_shift   <= '0;
            word_done  <= 1'b0;
            got_word   <= 1'b0;
            o_RX_DV    <= 1'b0;
            o_RX_Byte  <= '0;
            o_RX_Count <= '0;
        end else begin
            word_done <= rx_evt && last_bit;
            o_RX_DV   <= word_done;
            if (word_done) o_RX_Byte <= rx_shift;

            if (frame_start || frame_end) bit_cnt <= '0;
            else if (rx_evt)              bit_cnt <= last_bit ? '0 : bit_cnt + BIT_W'(1);

            if (rx_evt) rx_shift <= {rx_shift[DATA_W-2:0], mosi_s2};

            if (frame_start)            got_word <= 1'b0;
            else if (rx_evt && last_bit) got_word <= 1'b1;

            if (!in_shift)      o_RX_Count <= '0;
            else if (word_done) o_RX_Count <= o_RX_Count + COUNT_W'(1);
        end
    end

    // Transmit path: hold register, shifter reload at word boundaries with same-cycle bypass, MISO.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            tx_shift   <= TX_IDLE_WORD;
            tx_hold    <= '0;
            tx_pending <= 1'b0;
            o_SPI_MISO <= 1'b1;
        end else begin
            if (load_evt) begin
                if (tx_pending) begin
                    tx_shift   <= tx_hold;
                    tx_pending <= 1'b0;
                end else if (i_TX_DV) begin
                    tx_shift <= i_TX_Byte;
                end else begin
                    tx_shift <= TX_IDLE_WORD;
                end
            end else begin
                if (shift_evt) tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
                if (i_TX_DV && !tx_pending) begin
                    tx_hold    <= i_TX_Byte;
                    tx_pending <= 1'b1;
                end
            end
            o_SPI_MISO <= in_shift ? tx_shift[DATA_W-1] : 1'b1;
        end
    end

`ifdef SPI_SLAVE_FRAME_ERR_EN
    // Flag frames that end mid-word or carry no complete word.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) o_Frame_Err <= 1'b0;
        else          o_Frame_Err <= frame_end && ((bit_cnt != '0) || !got_word);
    end
`endif

endmodule

// File: tb/tb_spi_slave_single_cs.sv
// tb/tb_spi_slave_single_cs.sv - self-checking bench for spi_slave_single_cs
module tb_spi_slave_single_cs;

    logic       clk = 1'b0;
    logic       rst_l;
    logic       rx_dv;
    logic [7:0] rx_byte;
    logic [7:0] rx_count;
    logic       tx_dv;
    logic [7:0] tx_byte;
    logic       tx_ready;
    logic       busy;
    logic       spi_clk;
    logic       spi_mosi;
    logic       spi_miso;
    logic       spi_cs_n;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    logic       frame_err;
    int         err_pulses = 0;
`endif

    int tests = 0;
    int fails = 0;

    logic [7:0] rx_q[$];
    logic [7:0] cnt_q[$];

    typedef struct {
        bit         start_frame;
        bit         load_tx;
        logic [7:0] tx;
        logic [7:0] mosi;
        logic [7:0] exp_miso;
        logic [7:0] exp_cnt;
    } vec_t;

    vec_t vecs[7];

    spi_slave_single_cs dut (
        .i_Clk      (clk),
        .i_Rst_L    (rst_l),
        .o_RX_DV    (rx_dv),
        .o_RX_Byte  (rx_byte),
        .o_RX_Count (rx_count),
        .i_TX_DV    (tx_dv),
        .i_TX_Byte  (tx_byte),
        .o_TX_Ready (tx_ready),
        .o_Busy     (busy),
`ifdef SPI_SLAVE_FRAME_ERR_EN
        .o_Frame_Err(frame_err),
`endif
        .i_SPI_Clk  (spi_clk),
        .i_SPI_MOSI (spi_mosi),
        .o_SPI_MISO (spi_miso),
        .i_SPI_CS_n (spi_cs_n)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_dv) begin
            rx_q.push_back(rx_byte);
            cnt_q.push_back(rx_count);
        end
`ifdef SPI_SLAVE_FRAME_ERR_EN
        if (frame_err) err_pulses++;
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic xfer_bits(input logic [7:0] w, input int n, output logic [7:0] miso_w);
        miso_w = '0;
        for (int i = 7; i > 7 - n; i--) begin
            spi_clk  = 1'b0;
            spi_mosi = w[i];
            repeat (4) tick();
            miso_w  = {miso_w[6:0], spi_miso};
            spi_clk = 1'b1;
            repeat (4) tick();
        end
    endtask

    task automatic start_frame();
        spi_cs_n = 1'b0;
        repeat (8) tick();
    endtask

    task automatic end_frame();
        spi_clk = 1'b0;
        repeat (6) tick();
        spi_cs_n = 1'b1;
        repeat (8) tick();
    endtask

    task automatic load_tx(input logic [7:0] b);
        tx_byte = b;
        tx_dv   = 1'b1;
        tick();
        tx_dv   = 1'b0;
    endtask

    task automatic check_word(input string name, input logic [7:0] exp_b, input logic [7:0] exp_c);
        int n;
        logic [7:0] b, c;
        n = rx_q.size();
        check({name, " strobes"}, n, 1);
        if (n > 0) begin
            b = rx_q.pop_front();
            c = cnt_q.pop_front();
            check({name, " rx_byte"}, b, exp_b);
            check({name, " rx_count"}, c, exp_c);
        end
        rx_q.delete();
        cnt_q.delete();
    endtask

    initial begin
        logic [7:0] miso_w;
        int         waited;
        int         data_bad, cnt_bad, strobes;
        logic [7:0] b, c, c254, c255;

        vecs[0] = '{1, 0, 8'h00, 8'hAB, 8'hFF, 8'd1};
        vecs[1] = '{0, 0, 8'h00, 8'hCD, 8'hFF, 8'd2};
        vecs[2] = '{1, 1, 8'h5A, 8'h11, 8'h5A, 8'd1};
        vecs[3] = '{0, 1, 8'h3C, 8'h22, 8'h3C, 8'd2};
        vecs[4] = '{0, 0, 8'h00, 8'h33, 8'hFF, 8'd3};
        vecs[5] = '{1, 1, 8'hC3, 8'h00, 8'hC3, 8'd1};
        vecs[6] = '{0, 0, 8'h00, 8'hFF, 8'hFF, 8'd2};

        rst_l = 1'b0; tx_dv = 1'b0; tx_byte = '0;
        spi_clk = 1'b0; spi_mosi = 1'b0; spi_cs_n = 1'b1;
        repeat (3) tick();
        check("reset rx_dv", rx_dv, 0);
        check("reset rx_byte", rx_byte, 0);
        check("reset rx_count", rx_count, 0);
        check("reset tx_ready", tx_ready, 1);
        check("reset busy", busy, 0);
        check("reset miso", spi_miso, 1);
        rst_l = 1'b1;
        repeat (6) tick();

        for (int i = 0; i < 7; i++) begin
            if (vecs[i].start_frame) begin
                if (i != 0) end_frame();
                if (vecs[i].load_tx) begin
                    load_tx(vecs[i].tx);
                    check($sformatf("v%0d preload tx_ready", i), tx_ready, 0);
                    load_tx(8'h77);
                end
                start_frame();
                check($sformatf("v%0d busy", i), busy, 1);
            end else if (vecs[i].load_tx) begin
                waited = 0;
                while (!tx_ready && waited < 100) begin
                    tick();
                    waited++;
                end
                check($sformatf("v%0d tx_ready wait", i), tx_ready, 1);
                load_tx(vecs[i].tx);
            end
            xfer_bits(vecs[i].mosi, 8, miso_w);
            repeat (2) tick();
            check($sformatf("v%0d miso", i), miso_w, vecs[i].exp_miso);
            check_word($sformatf("v%0d", i), vecs[i].mosi, vecs[i].exp_cnt);
        end
        end_frame();

        // Chip select released after 5 bits of 0xA5.
`ifdef SPI_SLAVE_FRAME_ERR_EN
        check("no frame_err on clean frames", err_pulses, 0);
`endif
        start_frame();
        xfer_bits(8'hA5, 5, miso_w);
        end_frame();
        check("partial word no strobe", rx_q.size(), 0);
`ifdef SPI_SLAVE_FRAME_ERR_EN
        check("partial word frame_err", err_pulses, 1);
`endif

        // Next frame: count restarts, then TX_DV lands on the exact reload cycle.
        start_frame();
        check("count after partial", rx_count, 0);
        xfer_bits(8'h11, 8, miso_w);
        repeat (2) tick();
        check_word("reload w1", 8'h11, 8'd1);
        spi_clk = 1'b0;
        tick();
        tick();
        tx_byte = 8'h81;
        tx_dv   = 1'b1;
        tick();
        tx_dv   = 1'b0;
        check("bypass tx_ready", tx_ready, 1);
        xfer_bits(8'h22, 8, miso_w);
        repeat (2) tick();
        check("bypass miso", miso_w, 8'h81);
        check_word("reload w2", 8'h22, 8'd2);
        end_frame();

        // Reset mid-word with CS_n held low: rest of that frame ignored.
        start_frame();
        xfer_bits(8'h0F, 3, miso_w);
        rst_l = 1'b0;
        tick();
        tick();
        rst_l = 1'b1;
        tick();
        xfer_bits(8'hFF, 8, miso_w);
        xfer_bits(8'h00, 8, miso_w);
        spi_clk = 1'b0;
        repeat (6) tick();
        check("post-reset no strobe", rx_q.size(), 0);
        check("post-reset busy", busy, 0);
        check("post-reset rx_byte", rx_byte, 0);
        end_frame();
        start_frame();
        xfer_bits(8'h96, 8, miso_w);
        repeat (2) tick();
        check("after reset miso", miso_w, 8'hFF);
        check_word("after reset", 8'h96, 8'd1);
        end_frame();

        // 256 words in one frame: count wraps 255 -> 0.
        data_bad = 0; cnt_bad = 0; strobes = 0; c254 = 8'h00; c255 = 8'hEE;
        start_frame();
        for (int k = 0; k < 256; k++) begin
            xfer_bits(8'(k * 37 + 5), 8, miso_w);
            repeat (2) tick();
            while (rx_q.size() > 0) begin
                b = rx_q.pop_front();
                c = cnt_q.pop_front();
                if (b != 8'(k * 37 + 5)) data_bad++;
                if (c != 8'(k + 1)) cnt_bad++;
                if (k == 254) c254 = c;
                if (k == 255) c255 = c;
                strobes++;
            end
        end
        end_frame();
        check("256 strobes", strobes, 256);
        check("256 data errors", data_bad, 0);
        check("256 count errors", cnt_bad, 0);
        check("count at word 255", c254, 8'd255);
        check("count wrap at word 256", c255, 8'd0);
        check("idle rx_count", rx_count, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
